// File: rtl/stopwatch_pkg.sv
// Shared constants, field-select encoding and wrap helpers for the stopwatch counting core.
package stopwatch_pkg;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  localparam logic CUR_LEFT  = 1'b0;
  localparam logic CUR_RIGHT = 1'b1;

  // Encoding is {sel_display, cursor} so the select can be cast directly.
  typedef enum logic [1:0] {
    FLD_SEC  = 2'b00,
    FLD_MSEC = 2'b01,
    FLD_HOUR = 2'b10,
    FLD_MIN  = 2'b11
  } field_sel_e;

  function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] max);
    logic [6:0] r;
    if (v >= max) begin
      r = 7'd0;
    end else begin
      r = v + 7'd1;
    end
    return r;
  endfunction

  function automatic logic [6:0] wrap_dec(input logic [6:0] v, input logic [6:0] max);
    logic [6:0] r;
    if (v == 7'd0) begin
      r = max;
    end else begin
      r = v - 7'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running CLK_FREQ/TICK_HZ divider with enable and synchronous clear; tick is one
// cycle wide at the terminal count.
module tick_gen #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_term_s;

  assign at_term_s = (cnt_q == TERM);
  assign tick_o    = en_i & ~clr_i & at_term_s;

  // divider next-state: clear wins, then advance/wrap while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_term_s ? '0 : cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // divider register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch/timer counting core: hour:min:sec:centisecond value that counts up or down on
// a 100 Hz tick, with per-field manual editing and a down-count expiry flag.
module stopwatch_datapath
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              clear,
  input  logic              run_stop,
  input  logic              sw_1,
  input  logic              sel_display,
  input  logic              digit_l,
  input  logic              digit_r,
  input  logic              time_up,
  input  logic              time_down,
  output logic [MSEC_W-1:0] msec,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              time_out
);

  logic [MSEC_W-1:0] msec_q, msec_d;
  logic [SEC_W-1:0]  sec_q,  sec_d;
  logic [MIN_W-1:0]  min_q,  min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              time_out_q, time_out_d;
  logic              cursor_q, cursor_d;

  logic              tick_s;
  logic              div_en_s;
  logic              edit_s;
  logic              all_zero_s;
  field_sel_e        fld_sel_s;
  logic [6:0]        fld_cur_s;
  logic [6:0]        fld_max_s;
  logic [6:0]        fld_new_s;

  assign div_en_s   = run_stop & ~sw_1 & ~time_out_q;
  assign edit_s     = sw_1 & (time_up ^ time_down);
  assign all_zero_s = ({hour_q, min_q, sec_q, msec_q} == 24'd0);
  assign fld_sel_s  = field_sel_e'({sel_display, cursor_q});

  tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (clear),
    .en_i   (div_en_s),
    .tick_o (tick_s)
  );

  // cursor: one-sided pulses move it, simultaneous pulses cancel
  always_comb begin
    cursor_d = cursor_q;
    if (digit_l && !digit_r) begin
      cursor_d = CUR_LEFT;
    end else if (digit_r && !digit_l) begin
      cursor_d = CUR_RIGHT;
    end else begin
      cursor_d = cursor_q;
    end
  end

  // widen the selected field to 7 bits so one wrap helper serves all fields
  always_comb begin
    fld_cur_s = 7'd0;
    fld_max_s = 7'd0;
    case (fld_sel_s)
      FLD_HOUR: begin
        fld_cur_s = {2'b00, hour_q};
        fld_max_s = {2'b00, HOUR_MAX};
      end
      FLD_MIN: begin
        fld_cur_s = {1'b0, min_q};
        fld_max_s = {1'b0, MIN_MAX};
      end
      FLD_SEC: begin
        fld_cur_s = {1'b0, sec_q};
        fld_max_s = {1'b0, SEC_MAX};
      end
      FLD_MSEC: begin
        fld_cur_s = msec_q;
        fld_max_s = MSEC_MAX;
      end
      default: begin
        fld_cur_s = 7'd0;
        fld_max_s = 7'd0;
      end
    endcase
    fld_new_s = time_up ? wrap_inc(fld_cur_s, fld_max_s) : wrap_dec(fld_cur_s, fld_max_s);
  end

  // time value and expiry next-state: clear > edit > tick
  always_comb begin
    msec_d     = msec_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    time_out_d = time_out_q;
    if (clear) begin
      msec_d     = 7'd0;
      sec_d      = 6'd0;
      min_d      = 6'd0;
      hour_d     = 5'd0;
      time_out_d = 1'b0;
    end else if (edit_s) begin
      case (fld_sel_s)
        FLD_HOUR: hour_d = fld_new_s[4:0];
        FLD_MIN:  min_d  = fld_new_s[5:0];
        FLD_SEC:  sec_d  = fld_new_s[5:0];
        FLD_MSEC: msec_d = fld_new_s;
        default:  msec_d = msec_q;
      endcase
      if ({hour_d, min_d, sec_d, msec_d} != 24'd0) begin
        time_out_d = 1'b0;
      end else begin
        time_out_d = time_out_q;
      end
    end else if (tick_s) begin
      if (!mode) begin
        if (msec_q != MSEC_MAX) begin
          msec_d = msec_q + 7'd1;
        end else begin
          msec_d = 7'd0;
          if (sec_q != SEC_MAX) begin
            sec_d = sec_q + 6'd1;
          end else begin
            sec_d = 6'd0;
            if (min_q != MIN_MAX) begin
              min_d = min_q + 6'd1;
            end else begin
              min_d  = 6'd0;
              hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
            end
          end
        end
      end else if (all_zero_s) begin
        time_out_d = 1'b1;
      end else if (msec_q != 7'd0) begin
        msec_d = msec_q - 7'd1;
      end else begin
        msec_d = MSEC_MAX;
        if (sec_q != 6'd0) begin
          sec_d = sec_q - 6'd1;
        end else begin
          sec_d = SEC_MAX;
          if (min_q != 6'd0) begin
            min_d = min_q - 6'd1;
          end else begin
            // a nonzero value with zero min/sec/msec always has hour > 0
            min_d  = MIN_MAX;
            hour_d = hour_q - 5'd1;
          end
        end
      end
    end else begin
      time_out_d = time_out_q;
    end
    time_out_d = time_out_d & mode;
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msec_q     <= 7'd0;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hour_q     <= 5'd0;
      time_out_q <= 1'b0;
      cursor_q   <= CUR_LEFT;
    end else begin
      msec_q     <= msec_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      time_out_q <= time_out_d;
      cursor_q   <= cursor_d;
    end
  end

  assign msec     = msec_q;
  assign sec      = sec_q;
  assign min      = min_q;
  assign hour     = hour_q;
  assign time_out = time_out_q;

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Directed self-checking bench for stopwatch_datapath with the divider shortened to 10 cycles.
module tb_stopwatch_datapath;

  logic       clk;
  logic       reset;
  logic       mode;
  logic       clear;
  logic       run_stop;
  logic       sw_1;
  logic       sel_display;
  logic       digit_l;
  logic       digit_r;
  logic       time_up;
  logic       time_down;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       time_out;

  int n_checks;
  int n_pass;

  localparam logic [3:0] P_L  = 4'b1000;
  localparam logic [3:0] P_R  = 4'b0100;
  localparam logic [3:0] P_UP = 4'b0010;
  localparam logic [3:0] P_DN = 4'b0001;

  stopwatch_datapath #(
    .CLK_FREQ (1000),
    .TICK_HZ  (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .clear       (clear),
    .run_stop    (run_stop),
    .sw_1        (sw_1),
    .sel_display (sel_display),
    .digit_l     (digit_l),
    .digit_r     (digit_r),
    .time_up     (time_up),
    .time_down   (time_down),
    .msec        (msec),
    .sec         (sec),
    .min         (min),
    .hour        (hour),
    .time_out    (time_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] m);
    {digit_l, digit_r, time_up, time_down} = m;
    cyc(1);
    {digit_l, digit_r, time_up, time_down} = 4'b0000;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s, input int ms);
    logic [23:0] e;
    e = {h[4:0], m[5:0], s[5:0], ms[6:0]};
    chk(tag, {8'd0, hour, min, sec, msec}, {8'd0, e});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b0; mode = 1'b0; clear = 1'b0; run_stop = 1'b0; sw_1 = 1'b0;
    sel_display = 1'b0; digit_l = 1'b0; digit_r = 1'b0; time_up = 1'b0; time_down = 1'b0;

    // reset and idle
    cyc(2);
    reset = 1'b1;
    cyc(50);
    chk_time("idle_value", 0, 0, 0, 0);
    chk("idle_timeout", {31'd0, time_out}, 32'd0);

    // up count 30 ticks
    run_stop = 1'b1;
    cyc(300);
    run_stop = 1'b0;
    chk_time("up30", 0, 0, 0, 30);

    // clear then preload 23:59:59:99 by single decrements
    do_clear();
    chk_time("clear_idle", 0, 0, 0, 0);
    sw_1 = 1'b1;
    sel_display = 1'b1;
    pulse(P_L); pulse(P_DN);
    chk("edit_hour_wrap", {27'd0, hour}, 32'd23);
    pulse(P_R); pulse(P_DN);
    sel_display = 1'b0;
    pulse(P_L); pulse(P_DN);
    pulse(P_R); pulse(P_DN);
    sw_1 = 1'b0;
    chk_time("preload", 23, 59, 59, 99);
    run_stop = 1'b1;
    cyc(9);
    chk_time("before_first_tick", 23, 59, 59, 99);
    cyc(1);
    chk_time("rollover", 0, 0, 0, 0);
    run_stop = 1'b0;

    // field edits, no counting while editing
    sw_1 = 1'b1;
    sel_display = 1'b1;
    pulse(P_L); pulse(P_UP); pulse(P_UP); pulse(P_UP);
    chk("edit_hour3", {27'd0, hour}, 32'd3);
    pulse(P_R); pulse(P_DN);
    chk("edit_min59", {26'd0, min}, 32'd59);
    sel_display = 1'b0;
    pulse(P_R); pulse(P_UP | P_DN);
    chk("edit_both_ignored", {25'd0, msec}, 32'd0);
    run_stop = 1'b1;
    cyc(40);
    run_stop = 1'b0;
    chk_time("edit_holds_count", 3, 59, 0, 0);
    sw_1 = 1'b0;
    pulse(P_UP);
    chk_time("edit_pulse_no_sw1", 3, 59, 0, 0);

    // down count from 00:00:01:02
    do_clear();
    sw_1 = 1'b1;
    sel_display = 1'b0;
    pulse(P_L); pulse(P_UP);
    pulse(P_R); pulse(P_UP); pulse(P_UP);
    sw_1 = 1'b0;
    chk_time("down_start", 0, 0, 1, 2);
    mode = 1'b1;
    run_stop = 1'b1;
    cyc(10); chk_time("down_1", 0, 0, 1, 1);
    cyc(10); chk_time("down_2", 0, 0, 1, 0);
    cyc(10); chk_time("down_borrow", 0, 0, 0, 99);
    cyc(990);
    chk_time("down_zero", 0, 0, 0, 0);
    chk("down_zero_no_to", {31'd0, time_out}, 32'd0);
    cyc(10);
    chk("expire_to", {31'd0, time_out}, 32'd1);
    chk_time("expire_value", 0, 0, 0, 0);
    cyc(30);
    chk("expire_hold", {31'd0, time_out}, 32'd1);
    mode = 1'b0;
    cyc(1);
    chk("mode0_clears_to", {31'd0, time_out}, 32'd0);
    cyc(10);
    chk_time("resume_up", 0, 0, 0, 1);
    run_stop = 1'b0;

    // mode switch mid-run
    do_clear();
    run_stop = 1'b1;
    cyc(300);
    chk_time("sw_up30", 0, 0, 0, 30);
    mode = 1'b1;
    cyc(300);
    chk_time("sw_down_zero", 0, 0, 0, 0);
    chk("sw_down_zero_to", {31'd0, time_out}, 32'd0);
    cyc(200);
    chk("sw_expired", {31'd0, time_out}, 32'd1);
    chk_time("sw_expired_value", 0, 0, 0, 0);
    mode = 1'b0;
    cyc(501);
    chk_time("sw_up50", 0, 0, 0, 50);
    chk("sw_up50_to", {31'd0, time_out}, 32'd0);

    // clear mid-run restarts the divider
    cyc(5);
    do_clear();
    chk_time("midrun_clear", 0, 0, 0, 0);
    cyc(9);
    chk_time("post_clear_wait", 0, 0, 0, 0);
    cyc(1);
    chk_time("post_clear_tick", 0, 0, 0, 1);

    // clear while expired
    mode = 1'b1;
    cyc(20);
    chk("to_before_clear", {31'd0, time_out}, 32'd1);
    do_clear();
    chk("clear_drops_to", {31'd0, time_out}, 32'd0);
    cyc(9);
    chk("to_rearm_wait", {31'd0, time_out}, 32'd0);
    cyc(1);
    chk("to_rearm", {31'd0, time_out}, 32'd1);

    // nonzero edit clears expiry
    sw_1 = 1'b1;
    sel_display = 1'b0;
    pulse(P_R); pulse(P_UP);
    chk("edit_clears_to", {31'd0, time_out}, 32'd0);
    chk_time("edit_after_to", 0, 0, 0, 1);
    sw_1 = 1'b0;
    run_stop = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_datapath.md
Name: stopwatch_datapath

Overview:
Counting core of the stopwatch/timer. It holds the hour:min:sec:centisecond time value and advances it on an internal 100 Hz tick. The value counts up in stopwatch mode and down in timer mode, and fields can be edited manually. It sits between the button/switch control unit (which supplies level and one-cycle pulse controls) and the FND display formatter (which consumes msec/sec/min/hour).

Parameters:
CLK_FREQ, 100_000_000, input clock frequency in Hz.
TICK_HZ, 100, count-tick rate; one tick = one msec LSB (10 ms).
DIV (derived, localparam), CLK_FREQ/TICK_HZ, divider terminal count; benches may override CLK_FREQ to shorten simulation.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset (reset=0 clears everything).
mode  input  1  level; 0 = count up (stopwatch), 1 = count down (timer).
clear  input  1  level/pulse; synchronous clear of time value, divider and time_out.
run_stop  input  1  level; 1 = run, 0 = hold.
sw_1  input  1  level; 1 = edit mode (counting paused, up/down edit enabled).
sel_display  input  1  level; 1 = hour/min pair selected, 0 = sec/msec pair.
digit_l  input  1  one-cycle pulse; selects left field of the pair.
digit_r  input  1  one-cycle pulse; selects right field of the pair.
time_up  input  1  one-cycle pulse; increment the selected field (edit mode only).
time_down  input  1  one-cycle pulse; decrement the selected field (edit mode only).
msec  output  7  centiseconds 0..99.
sec  output  6  seconds 0..59.
min  output  6  minutes 0..59.
hour  output  5  hours 0..23.
time_out  output  1  level; 1 while a down-count has expired at 00:00:00:00.

Behaviour:
- Reset (reset=0, async): msec/sec/min/hour=0; time_out=0; divider=0; field cursor=left.
- Priority per cycle: reset > clear > edit > count.
- Divider: counts 0..DIV-1 when run_stop=1, sw_1=0 and time_out=0; otherwise holds. Tick is asserted for one cycle at DIV-1, and the divider then wraps to 0. First tick occurs DIV cycles after run begins; outputs update on the cycle after the tick.
- Up count (mode=0), on each tick:
  - msec increments 99->0 with carry to sec; sec 59->0 with carry to min; min 59->0 with carry to hour; hour 23->0.
  - No time_out in up mode.
- Down count (mode=1), on each tick:
  - msec decrements 0->99 with borrow; sec and min 0->59 with borrow; hour decrements.
  - When a tick would decrement from all-zero, the value stays 0 and time_out is set.
  - If the value is already all-zero when mode=1 and running, time_out is set on the next tick.
- time_out: once set, holds and blocks counting. Cleared by clear, by mode returning to 0, or by any edit that leaves a nonzero value.
- Mode change mid-run: the value is preserved, the direction changes from the next tick, and the divider is not reset.
- clear: synchronous. All fields=0, divider=0, time_out=0. Does not change the field cursor.
- Field cursor: 1-bit register. digit_l sets it to left, digit_r sets it to right; both together means no change. Updates in any mode.
- Selected field by {sel_display, cursor}: (1,L)=hour, (1,R)=min, (0,L)=sec, (0,R)=msec.
- Edit (sw_1=1):
  - Divider held.
  - time_up increments the selected field only, wrapping within its own range (99/59/59/23 -> 0) with no carry.
  - time_down decrements the selected field only, wrapping 0 -> max with no borrow.
  - time_up and time_down in the same cycle: ignored.
  - Edit pulses while sw_1=0 are ignored.
- All outputs are registered, with no combinational path from inputs.

Decomposition:
- Shared package stopwatch_pkg: constants MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23; field widths 7/6/6/5; field-select encoding (HOUR, MIN, SEC, MSEC).
- One natural sub-module: tick_gen (parameterised CLK_FREQ/TICK_HZ divider with enable and sync clear, producing a one-cycle tick).
- Field counters live in the top module, one wrap/carry stage per field.

Test Plan:
- Reset/idle: reset=0 then release with run_stop=0 for 5*DIV cycles -> all outputs 0, time_out=0.
- Up count with DIV shortened to 10: run_stop=1, mode=0 for 30 ticks -> msec=30. Preload 23:59:59:99 via edit, then one tick -> 00:00:00:00.
- Down count: mode=1 from sec=1, msec=2 -> sequence 01:01, 01:00, 00:99 ... 00:00. Next tick sets time_out=1 and the value stays 0. Setting mode=0 clears time_out and counting resumes upward.
- Mode switch mid-run: up-count 30 ticks (msec=30), mode=1 for 50 ticks -> 0 reached at tick 30, time_out=1 held. mode=0 then 50 ticks -> msec=50.
- Edit:
  - sw_1=1, sel_display=1, digit_l, time_up x3 -> hour=3.
  - digit_r, time_down -> min=59.
  - sel_display=0, digit_r, time_up and time_down together -> msec unchanged.
  - No ticks advance while sw_1=1.
- clear mid-run: clear asserted with nonzero value and time_out=1 -> next cycle all fields 0, time_out=0, first post-clear tick DIV cycles later.
